// File: rtl/bconv_output_packer.sv
// bconv_output_packer
// Packs the binary-convolution result stream, one bit per pixel, into
// DATA_WIDTH-bit words. The first bit of each word goes in the LSB. The
// words are written to the output SRAM at consecutive addresses, starting
// at BASE_ADDR. busy stays high until the final write has been presented,
// so busy falls on the edge that commits the last word.
module bconv_output_packer #(
    parameter int                    DATA_WIDTH = 16,
    parameter int                    ADDR_WIDTH = 12,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
    input  logic                  clk,
    input  logic                  reset_b,
    input  logic                  start,
    input  logic                  bit_valid,
    input  logic                  bit_data,
    input  logic                  frame_last,
    output logic                  bit_ready,
    output logic                  dut_sram_write_enable,
    output logic [ADDR_WIDTH-1:0] dut_sram_write_address,
    output logic [DATA_WIDTH-1:0] dut_sram_write_data,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow,
    output logic [ADDR_WIDTH:0]   words_written
);

    localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_DONE
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic                  w_bit_ready;
    logic                  w_busy;
    logic                  w_done;

    logic [ADDR_WIDTH-1:0] r_addr;
    logic [IDX_W-1:0]      r_idx;
    logic [DATA_WIDTH-1:0] r_shift;
    logic                  r_we;
    logic [ADDR_WIDTH-1:0] r_wr_addr;
    logic [DATA_WIDTH-1:0] r_wr_data;
    logic [ADDR_WIDTH:0]   r_words;
    logic                  r_ovf;

    logic                  w_restart;
    logic                  w_take;
    logic                  w_close;
    logic [DATA_WIDTH-1:0] w_word;

    // A start in DONE is ignored. Anywhere else it (re)initialises the frame.
    assign w_restart = start & (r_state != S_DONE);
    // A start that arrives with a bit aborts the frame, so that bit is dropped.
    assign w_take    = bit_valid & w_bit_ready & ~start;
    assign w_close   = w_take & ((r_idx == LAST_IDX) | frame_last);
    assign w_word    = r_shift | (DATA_WIDTH'(bit_data) << r_idx);

    // State register
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and state-decoded outputs
    always_comb begin
        w_next      = r_state;
        w_bit_ready = 1'b0;
        w_busy      = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) w_next = S_COLLECT;
            end
            S_COLLECT: begin
                w_bit_ready = 1'b1;
                w_busy      = 1'b1;
                if (start) begin
                    w_next = S_COLLECT;
                end else if (w_take && frame_last) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                w_busy = 1'b1;
                w_done = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Packing, address and counter datapath. Also holds the registered write port.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            r_addr    <= BASE_ADDR;
            r_idx     <= '0;
            r_shift   <= '0;
            r_we      <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            r_words   <= '0;
            r_ovf     <= 1'b0;
        end else begin
            r_we <= 1'b0;
            if (w_restart) begin
                r_addr  <= BASE_ADDR;
                r_idx   <= '0;
                r_shift <= '0;
                r_words <= '0;
                r_ovf   <= 1'b0;
            end else if (w_take) begin
                if (w_close) begin
                    r_we      <= 1'b1;
                    r_wr_addr <= r_addr;
                    r_wr_data <= w_word;
                    r_addr    <= r_addr + ADDR_WIDTH'(1);
                    r_words   <= r_words + (ADDR_WIDTH + 1)'(1);
                    if (&r_addr) r_ovf <= 1'b1;
                    r_idx     <= '0;
                    r_shift   <= '0;
                end else begin
                    r_shift <= w_word;
                    r_idx   <= r_idx + IDX_W'(1);
                end
            end
        end
    end

    assign bit_ready              = w_bit_ready;
    assign busy                   = w_busy;
    assign done                   = w_done;
    assign dut_sram_write_enable  = r_we;
    assign dut_sram_write_address = r_wr_addr;
    assign dut_sram_write_data    = r_wr_data;
    assign overflow               = r_ovf;
    assign words_written          = r_words;

endmodule

// File: tb/tb_bconv_output_packer.sv
// Testbench for bconv_output_packer. Two instances share the stimulus:
// one uses BASE_ADDR 0 and the other uses BASE_ADDR 12'hFFF, to exercise
// address wrap. Expected writes are queued when bits are driven and are
// popped when a write strobe is seen.
module tb_bconv_output_packer;

    logic        clk = 1'b0;
    logic        reset_b = 1'b1;
    logic        start = 1'b0;
    logic        bit_valid = 1'b0;
    logic        bit_data = 1'b0;
    logic        frame_last = 1'b0;

    logic        ready0, we0, busy0, done0, ovf0;
    logic [11:0] wa0;
    logic [15:0] wd0;
    logic [12:0] ww0;
    logic        ready1, we1, busy1, done1, ovf1;
    logic [11:0] wa1;
    logic [15:0] wd1;
    logic [12:0] ww1;

    int errors = 0;
    int checks = 0;

    logic [27:0] q0[$];
    logic [27:0] q1[$];
    logic [27:0] e0, e1;
    logic [11:0] a0, a1;
    logic [15:0] m_shift;
    int          m_idx;

    always #5 clk = ~clk;

    bconv_output_packer #(.DATA_WIDTH(16), .ADDR_WIDTH(12), .BASE_ADDR(12'h000)) u_dut (
        .clk(clk), .reset_b(reset_b), .start(start), .bit_valid(bit_valid),
        .bit_data(bit_data), .frame_last(frame_last), .bit_ready(ready0),
        .dut_sram_write_enable(we0), .dut_sram_write_address(wa0),
        .dut_sram_write_data(wd0), .busy(busy0), .done(done0),
        .overflow(ovf0), .words_written(ww0)
    );

    bconv_output_packer #(.DATA_WIDTH(16), .ADDR_WIDTH(12), .BASE_ADDR(12'hFFF)) u_wrap (
        .clk(clk), .reset_b(reset_b), .start(start), .bit_valid(bit_valid),
        .bit_data(bit_data), .frame_last(frame_last), .bit_ready(ready1),
        .dut_sram_write_enable(we1), .dut_sram_write_address(wa1),
        .dut_sram_write_data(wd1), .busy(busy1), .done(done1),
        .overflow(ovf1), .words_written(ww1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every strobe must match the oldest expected write
    always @(negedge clk) begin
        if (we0 === 1'b1) begin
            chk("w0_expected", 32'(q0.size() != 0), 32'd1);
            if (q0.size() != 0) begin
                e0 = q0.pop_front();
                chk("w0_addr", 32'(wa0), 32'(e0[27:16]));
                chk("w0_data", 32'(wd0), 32'(e0[15:0]));
            end
        end
        if (we1 === 1'b1) begin
            chk("w1_expected", 32'(q1.size() != 0), 32'd1);
            if (q1.size() != 0) begin
                e1 = q1.pop_front();
                chk("w1_addr", 32'(wa1), 32'(e1[27:16]));
                chk("w1_data", 32'(wd1), 32'(e1[15:0]));
            end
        end
    end

    task automatic model_clear();
        m_shift = '0;
        m_idx   = 0;
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        a0 = 12'h000;
        a1 = 12'hFFF;
        model_clear();
    endtask

    task automatic push_word();
        q0.push_back({a0, m_shift});
        q1.push_back({a1, m_shift});
        a0 = a0 + 12'd1;
        a1 = a1 + 12'd1;
        model_clear();
    endtask

    task automatic send_bit(input logic b, input logic last);
        bit_valid  = 1'b1;
        bit_data   = b;
        frame_last = last;
        @(posedge clk); #1;
        bit_valid  = 1'b0;
        bit_data   = 1'b0;
        frame_last = 1'b0;
        m_shift[m_idx] = b;
        m_idx++;
        if (m_idx == 16 || last) push_word();
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    // Called 1 time unit after the edge that accepted the final bit
    task automatic check_finish(input string tag, input int nwords);
        chk({tag, "_done0"}, 32'(done0), 32'd1);
        chk({tag, "_done1"}, 32'(done1), 32'd1);
        chk({tag, "_we_with_done"}, 32'(we0), 32'd1);
        chk({tag, "_busy_at_done"}, 32'(busy0), 32'd1);
        chk({tag, "_words0"}, 32'(ww0), 32'(nwords));
        chk({tag, "_words1"}, 32'(ww1), 32'(nwords));
        @(posedge clk); #1;
        chk({tag, "_busy0_fall"}, 32'(busy0), 32'd0);
        chk({tag, "_busy1_fall"}, 32'(busy1), 32'd0);
        chk({tag, "_done0_pulse"}, 32'(done0), 32'd0);
        chk({tag, "_we_single"}, 32'(we0), 32'd0);
    endtask

    initial begin
        model_clear();
        a0 = 12'h000;
        a1 = 12'hFFF;

        // Reset
        #2 reset_b = 1'b0;
        #1;
        chk("rst_we", 32'(we0), 32'd0);
        chk("rst_busy", 32'(busy0), 32'd0);
        chk("rst_done", 32'(done0), 32'd0);
        chk("rst_ready", 32'(ready0), 32'd0);
        chk("rst_ovf", 32'(ovf1), 32'd0);
        chk("rst_words", 32'(ww0), 32'd0);
        chk("rst_addr", 32'(wa1), 32'd0);
        chk("rst_data", 32'(wd0), 32'd0);
        @(posedge clk); @(posedge clk); #3;
        reset_b = 1'b1;
        @(posedge clk); #1;

        // 32-bit alternating frame
        do_start();
        chk("t1_ready", 32'(ready0), 32'd1);
        chk("t1_busy", 32'(busy0), 32'd1);
        for (int i = 0; i < 32; i++) send_bit(((i % 2) == 0), (i == 31));
        chk("t1_last_addr", 32'(wa0), 32'h001);
        chk("t1_last_data", 32'(wd0), 32'h5555);
        check_finish("t1", 2);

        // 20-bit frame of ones with a 3-cycle gap in the middle
        do_start();
        for (int i = 0; i < 20; i++) begin
            if (i == 8) idle_cycles(3);
            send_bit(1'b1, (i == 19));
        end
        chk("t2_last_addr", 32'(wa0), 32'h001);
        chk("t2_last_data", 32'(wd0), 32'h000F);
        check_finish("t2", 2);

        // Abort after 10 bits, then restart with 16 ones
        do_start();
        for (int i = 0; i < 10; i++) send_bit(((i % 3) == 0), 1'b0);
        do_start();
        chk("t3_restart_busy", 32'(busy0), 32'd1);
        chk("t3_restart_words", 32'(ww0), 32'd0);
        for (int i = 0; i < 16; i++) send_bit(1'b1, (i == 15));
        chk("t3_addr", 32'(wa0), 32'h000);
        chk("t3_data", 32'(wd0), 32'hFFFF);
        check_finish("t3", 1);

        // 32 zeros: the FFF-based instance wraps
        do_start();
        for (int i = 0; i < 32; i++) send_bit(1'b0, (i == 31));
        chk("t4_wrap_addr", 32'(wa1), 32'h000);
        chk("t4_ovf1", 32'(ovf1), 32'd1);
        chk("t4_ovf0", 32'(ovf0), 32'd0);
        check_finish("t4", 2);
        idle_cycles(3);
        chk("t4_ovf_sticky", 32'(ovf1), 32'd1);

        // Asynchronous reset mid-frame, between clock edges
        do_start();
        chk("t5_ovf_cleared", 32'(ovf1), 32'd0);
        for (int i = 0; i < 8; i++) send_bit(1'b1, 1'b0);
        #3 reset_b = 1'b0;
        #1;
        chk("t5_we", 32'(we0), 32'd0);
        chk("t5_busy", 32'(busy0), 32'd0);
        chk("t5_ready", 32'(ready0), 32'd0);
        chk("t5_addr", 32'(wa0), 32'd0);
        chk("t5_data1", 32'(wd1), 32'd0);
        model_clear();
        @(posedge clk); #3;
        reset_b = 1'b1;
        @(posedge clk); #1;
        do_start();
        for (int i = 0; i < 16; i++) send_bit(((i % 4) == 0), (i == 15));
        chk("t5_base0", 32'(wa0), 32'h000);
        chk("t5_base1", 32'(wa1), 32'hFFF);
        chk("t5_data", 32'(wd0), 32'h1111);
        check_finish("t5", 1);

        // bit_valid with frame_last while IDLE is ignored
        bit_valid  = 1'b1;
        bit_data   = 1'b1;
        frame_last = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("t6_busy", 32'(busy0), 32'd0);
            chk("t6_done", 32'(done0), 32'd0);
            chk("t6_we", 32'(we0), 32'd0);
        end
        bit_valid  = 1'b0;
        bit_data   = 1'b0;
        frame_last = 1'b0;
        chk("t6_words", 32'(ww0), 32'd1);

        idle_cycles(2);
        chk("q0_drained", 32'(q0.size()), 32'd0);
        chk("q1_drained", 32'(q1.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
